// File: rtl/parser_if.sv
// Word-stream ingress and record egress bundle for the packet parser.
// master = packet source / record sink, slave = parser.
interface parser_if #(
   parameter int MAX_PAYLOAD = 34
);
   logic [31:0]                   dataIn;
   logic                          dataIn_val;
   logic                          dataIn_ready;
   logic                          dataIN_last;
   logic [0:24+8*MAX_PAYLOAD-1]   dataOut;
   logic                          dataOut_val;
   logic                          dataOut_ready;
   logic                          packetLost;

   modport master (
      output dataIn, dataIn_val, dataIN_last, dataOut_ready,
      input  dataIn_ready, dataOut, dataOut_val, packetLost
   );

   modport slave (
      input  dataIn, dataIn_val, dataIN_last, dataOut_ready,
      output dataIn_ready, dataOut, dataOut_val, packetLost
   );
endinterface

// File: rtl/parser.sv
// Packet header parser: pulls length/stream/sequence out of a 32-bit word stream,
// emits one fixed-width record per packet and flags per-stream sequence gaps.
module parser #(
   parameter int NUM_STREAMS = 8,
   parameter int MAX_PAYLOAD = 34
) (
   input  logic    clk,
   input  logic    reset_b,
   parser_if.slave bus
);
   localparam int REC_W = 24 + 8 * MAX_PAYLOAD;
   localparam int PTR_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   logic                         accept, complete, isWord0, isWord1;
   logic [15:0]                  wordCount, lenReg, idReg;
   logic [31:0]                  seqNum;
   logic [MAX_PAYLOAD-1:0][7:0]  payloadReg, payloadNext;
   logic [0:REC_W-1]             recordNext, dataOutReg;
   logic                         dataOutValReg, packetLostReg;
   logic [15:0]                  lenSat;
   logic [17:0]                  wordBytes, byteCount;

   logic [NUM_STREAMS-1:0]       tblValid, hitVec;
   logic [15:0]                  tblId   [NUM_STREAMS];
   logic [31:0]                  tblLast [NUM_STREAMS];
   logic [PTR_W-1:0]             victimPtr, hitIdx, freeIdx, allocIdx;
   logic                         hit, hasFree;

   assign bus.dataIn_ready = !dataOutValReg || bus.dataOut_ready;
   assign accept    = bus.dataIn_val && bus.dataIn_ready;
   assign isWord0   = (wordCount == 16'd0);
   assign isWord1   = (wordCount == 16'd1);
   assign complete  = accept && bus.dataIN_last && !isWord0;
   assign seqNum    = {bus.dataIn[7:0], bus.dataIn[15:8], bus.dataIn[23:16], bus.dataIn[31:24]};

   assign bus.dataOut     = dataOutReg;
   assign bus.dataOut_val = dataOutValReg;
   assign bus.packetLost  = packetLostReg;

   // Saturates so an absurdly long packet cannot wrap back onto header positions.
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         wordCount <= '0;
      end else if (accept) begin
         if (bus.dataIN_last)
            wordCount <= '0;
         else if (wordCount != 16'hFFFF)
            wordCount <= wordCount + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         lenReg <= '0;
         idReg  <= '0;
      end else if (accept && isWord0) begin
         lenReg <= {bus.dataIn[23:16], bus.dataIn[31:24]};
         idReg  <= {bus.dataIn[7:0], bus.dataIn[15:8]};
      end
   end

   // Payload byte k lives in word k/4+2, lane k%4; word0 wipes the whole buffer.
   always_comb begin
      payloadNext = payloadReg;
      for (int k = 0; k < MAX_PAYLOAD; k++) begin
         if (accept && isWord0)
            payloadNext[k] = '0;
         else if (accept && wordCount == 16'(k / 4 + 2))
            payloadNext[k] = bus.dataIn[31 - 8 * (k % 4) -: 8];
      end
   end

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) payloadReg <= '0;
      else         payloadReg <= payloadNext;
   end

   always_comb begin
      lenSat    = (lenReg >= 16'd8) ? lenReg - 16'd8 : 16'd0;
      wordBytes = {wordCount - 16'd1, 2'b00};
      byteCount = {2'b00, lenSat};
      if (wordBytes < byteCount)
         byteCount = wordBytes;
      if (byteCount > 18'(MAX_PAYLOAD))
         byteCount = 18'(MAX_PAYLOAD);
   end

   // Record is built from the merged buffer so the final word lands in the same edge.
   always_comb begin
      recordNext        = '0;
      recordNext[0:15]  = idReg;
      recordNext[16:23] = byteCount[7:0];
      for (int k = 0; k < MAX_PAYLOAD; k++)
         recordNext[24 + 8 * k +: 8] = payloadNext[k];
   end

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         dataOutReg    <= '0;
         dataOutValReg <= 1'b0;
      end else if (complete) begin
         dataOutReg    <= recordNext;
         dataOutValReg <= 1'b1;
      end else if (dataOutValReg && bus.dataOut_ready) begin
         dataOutValReg <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STREAMS; gi++) begin : gHit
         assign hitVec[gi] = tblValid[gi] && (tblId[gi] == idReg);
      end
   endgenerate

   // Descending scan leaves the lowest matching / lowest free index.
   always_comb begin
      hit     = 1'b0;
      hitIdx  = '0;
      hasFree = 1'b0;
      freeIdx = '0;
      for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
         if (hitVec[i]) begin
            hit    = 1'b1;
            hitIdx = PTR_W'(i);
         end
         if (!tblValid[i]) begin
            hasFree = 1'b1;
            freeIdx = PTR_W'(i);
         end
      end
      allocIdx = hasFree ? freeIdx : victimPtr;
   end

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         tblValid      <= '0;
         victimPtr     <= '0;
         packetLostReg <= 1'b0;
         for (int i = 0; i < NUM_STREAMS; i++) begin
            tblId[i]   <= '0;
            tblLast[i] <= '0;
         end
      end else begin
         packetLostReg <= accept && isWord1 && hit && (seqNum != tblLast[hitIdx] + 32'd1);
         if (accept && isWord1) begin
            if (hit) begin
               tblLast[hitIdx] <= seqNum;
            end else begin
               tblValid[allocIdx] <= 1'b1;
               tblId[allocIdx]    <= idReg;
               tblLast[allocIdx]  <= seqNum;
               if (!hasFree)
                  victimPtr <= (victimPtr == PTR_W'(NUM_STREAMS - 1)) ? '0 : victimPtr + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_parser.sv
// Directed bench for parser: header decode, backpressure, sequence gaps,
// oversize/single-word packets and mid-packet reset.
module tb_parser;
   logic clk = 1'b0;
   logic reset_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lostCount = 0;
   int   lastLostCyc = -1;
   logic [0:295] recQ [$];
   logic [0:295] recBasic;

   parser_if bus ();

   parser dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.packetLost === 1'b1) begin
         lostCount   <= lostCount + 1;
         lastLostCyc <= cyc;
      end
      if (bus.dataOut_val === 1'b1 && bus.dataOut_ready === 1'b1)
         recQ.push_back(bus.dataOut);
   end

   function automatic logic [0:295] mkRec(input logic [15:0] id, input logic [7:0] cnt,
                                          input logic [31:0] w [16], input int n);
      logic [0:295] r;
      int k;
      r = '0;
      k = 0;
      r[0:15]  = id;
      r[16:23] = cnt;
      for (int i = 2; i < n; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (k < 34) r[24 + 8 * k +: 8] = w[i][31 - 8 * j -: 8];
            k++;
         end
      end
      return r;
   endfunction

   task automatic sendPacket(input logic [31:0] w [16], input int n, input bit withLast,
                             output int w1Cyc);
      w1Cyc = -1;
      for (int i = 0; i < n; i++) begin
         int t;
         bus.dataIn      = w[i];
         bus.dataIn_val  = 1'b1;
         bus.dataIN_last = withLast && (i == n - 1);
         t = 0;
         while (bus.dataIn_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (bus.dataIn_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word %0d ready=%b required 1", i, bus.dataIn_ready);
         end
         @(posedge clk);
         #1;
         if (i == 1) w1Cyc = cyc;
      end
      bus.dataIn_val  = 1'b0;
      bus.dataIN_last = 1'b0;
   endtask

   task automatic waitRec();
      int t;
      t = 0;
      while (recQ.size() == 0 && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
   endtask

   task automatic test_reset();
      bus.dataIn        = '0;
      bus.dataIn_val    = 1'b0;
      bus.dataIN_last   = 1'b0;
      bus.dataOut_ready = 1'b0;
      reset_b = 1'b0;
      #1 reset_b = 1'b1;
      #2;
      checks++;
      if (bus.dataOut_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", bus.dataOut_val); end
      checks++;
      if (bus.dataOut !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.dataOut); end
      checks++;
      if (bus.packetLost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b want 0", bus.packetLost); end
      checks++;
      if (bus.dataIn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.dataIn_ready); end
      @(negedge clk);
      @(negedge clk);
      reset_b = 1'b0;
      @(posedge clk);
      #1;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [31:0] w [16];
      int c1, lost0;
      w = '{default: '0};
      w[0] = 32'h14000C00; w[1] = 32'h01000000;
      w[2] = 32'h01234562; w[3] = 32'h01234563; w[4] = 32'h01234564;
      recBasic = mkRec(16'h000C, 8'h0C, w, 5);
      bus.dataOut_ready = 1'b0;
      lost0 = lostCount;
      sendPacket(w, 5, 1'b1, c1);
      checks++;
      if (bus.dataOut_val !== 1'b1) begin errors++; $display("FAIL basic_latency val got %b want 1", bus.dataOut_val); end
      checks++;
      if (bus.dataOut !== recBasic) begin errors++; $display("FAIL basic_record got %h want %h", bus.dataOut, recBasic); end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.dataOut_val !== 1'b1 || bus.dataOut !== recBasic) begin
         errors++; $display("FAIL basic_hold val %b data %h want 1 %h", bus.dataOut_val, bus.dataOut, recBasic);
      end
      @(posedge clk);
      #1;
      checks++;
      if (lostCount != lost0) begin errors++; $display("FAIL basic_no_loss pulses got %0d want 0", lostCount - lost0); end
      $display("test_basic stream 000C record %h", bus.dataOut[0:23]);
   endtask

   task automatic test_backpressure();
      logic [31:0] w [16];
      logic [0:295] exp2;
      int c1, lost0;
      w = '{default: '0};
      w[0] = 32'h19000D00; w[1] = 32'h01000000;
      w[2] = 32'h11111111; w[3] = 32'h22222222; w[4] = 32'h33333333; w[5] = 32'h44444444;
      exp2 = mkRec(16'h000D, 8'h10, w, 6);
      recQ.delete();
      lost0 = lostCount;
      bus.dataIn      = w[0];
      bus.dataIn_val  = 1'b1;
      bus.dataIN_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.dataIn_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d ready got %b want 0", i, bus.dataIn_ready); end
      end
      @(posedge clk);
      #1;
      bus.dataOut_ready = 1'b1;
      sendPacket(w, 6, 1'b1, c1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (recQ.size() != 2) begin
         errors++; $display("FAIL bp_records count got %0d want 2", recQ.size());
      end else begin
         checks++;
         if (recQ[0] !== recBasic) begin errors++; $display("FAIL bp_first got %h want %h", recQ[0], recBasic); end
         checks++;
         if (recQ[1] !== exp2) begin errors++; $display("FAIL bp_second got %h want %h", recQ[1], exp2); end
      end
      checks++;
      if (lostCount != lost0) begin errors++; $display("FAIL bp_no_loss pulses got %0d want 0", lostCount - lost0); end
      $display("test_backpressure stream 000D records %0d", recQ.size());
   endtask

   task automatic test_gap();
      logic [31:0] w [16];
      logic [0:295] exp3;
      int c1, lost0;
      w = '{default: '0};
      w[0] = 32'h27000C00; w[1] = 32'h03000000;
      w[2] = 32'hA0A1A2A3; w[3] = 32'hB0B1B2B3; w[4] = 32'hC0C1C2C3; w[5] = 32'hD0D1D2D3;
      w[6] = 32'hE0E1E2E3; w[7] = 32'hF0F1F2F3; w[8] = 32'h90919293;
      exp3 = mkRec(16'h000C, 8'h1C, w, 9);
      recQ.delete();
      lost0 = lostCount;
      sendPacket(w, 9, 1'b1, c1);
      waitRec();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (lostCount - lost0 != 1) begin errors++; $display("FAIL gap_pulse_count got %0d want 1", lostCount - lost0); end
      checks++;
      if (lastLostCyc != c1) begin errors++; $display("FAIL gap_pulse_time cycle got %0d want %0d", lastLostCyc, c1); end
      checks++;
      if (recQ.size() == 0) begin
         errors++; $display("FAIL gap_record none got 0 want 1");
      end else if (recQ[0] !== exp3) begin
         errors++; $display("FAIL gap_record got %h want %h", recQ[0], exp3);
      end
      checks++;
      if (bus.dataOut_val !== 1'b0) begin errors++; $display("FAIL gap_val_drop got %b want 0", bus.dataOut_val); end
      $display("test_gap stream 000C S=3 pulses %0d", lostCount - lost0);
   endtask

   task automatic test_seq();
      logic [31:0] w [16];
      logic [0:295] exp4;
      int c1, lost0;
      w = '{default: '0};
      w[0] = 32'h0C000C00; w[1] = 32'h04000000; w[2] = 32'hDEADBEEF;
      exp4 = mkRec(16'h000C, 8'h04, w, 3);
      recQ.delete();
      lost0 = lostCount;
      sendPacket(w, 3, 1'b1, c1);
      waitRec();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (lostCount != lost0) begin errors++; $display("FAIL seq_in_order pulses got %0d want 0", lostCount - lost0); end
      checks++;
      if (recQ.size() == 0 || recQ[0] !== exp4) begin
         errors++; $display("FAIL seq_record size %0d want record %h", recQ.size(), exp4);
      end
      lost0 = lostCount;
      sendPacket(w, 3, 1'b1, c1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (lostCount - lost0 != 1) begin errors++; $display("FAIL seq_repeat pulses got %0d want 1", lostCount - lost0); end
      $display("test_seq stream 000C S=4 twice pulses %0d", lostCount - lost0);
   endtask

   task automatic test_oversize();
      logic [31:0] w [16];
      logic [0:295] exp5;
      int c1, lost0;
      w = '{default: '0};
      w[0] = 32'h3C002000; w[1] = 32'h01000000;
      for (int i = 2; i < 15; i++) w[i] = 32'h01020304 + 32'(i - 2) * 32'h04040404;
      exp5 = mkRec(16'h0020, 8'h22, w, 15);
      recQ.delete();
      lost0 = lostCount;
      sendPacket(w, 15, 1'b1, c1);
      waitRec();
      checks++;
      if (recQ.size() == 0 || recQ[0] !== exp5) begin
         errors++; $display("FAIL oversize_record size %0d want record %h", recQ.size(), exp5);
      end
      repeat (2) @(posedge clk);
      #1;
      recQ.delete();
      w = '{default: '0};
      w[0] = 32'h08000500;
      sendPacket(w, 1, 1'b1, c1);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (recQ.size() != 0 || bus.dataOut_val !== 1'b0) begin
         errors++; $display("FAIL single_word records got %0d val %b want 0 0", recQ.size(), bus.dataOut_val);
      end
      w[0] = 32'h0C000500; w[1] = 32'h01000000; w[2] = 32'hCAFEF00D;
      exp5 = mkRec(16'h0005, 8'h04, w, 3);
      sendPacket(w, 3, 1'b1, c1);
      waitRec();
      checks++;
      if (recQ.size() == 0 || recQ[0] !== exp5) begin
         errors++; $display("FAIL after_single_record size %0d want record %h", recQ.size(), exp5);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (lostCount != lost0) begin errors++; $display("FAIL oversize_no_loss pulses got %0d want 0", lostCount - lost0); end
      $display("test_oversize count 34 then single-word drop");
   endtask

   task automatic test_reset_mid();
      logic [31:0] w [16];
      logic [0:295] exp6;
      int c1, lost0;
      w = '{default: '0};
      bus.dataOut_ready = 1'b0;
      w[0] = 32'h0C002100; w[1] = 32'h01000000; w[2] = 32'h55AA55AA;
      sendPacket(w, 3, 1'b1, c1);
      checks++;
      if (bus.dataOut_val !== 1'b1) begin errors++; $display("FAIL rst_held_before val got %b want 1", bus.dataOut_val); end
      @(negedge clk);
      #2 reset_b = 1'b1;
      #1;
      checks++;
      if (bus.dataOut_val !== 1'b0) begin errors++; $display("FAIL rst_async_val got %b want 0", bus.dataOut_val); end
      checks++;
      if (bus.dataOut !== '0) begin errors++; $display("FAIL rst_async_data got %h want 0", bus.dataOut); end
      @(negedge clk);
      reset_b = 1'b0;
      @(posedge clk);
      #1;
      bus.dataOut_ready = 1'b1;
      w = '{default: '0};
      w[0] = 32'h0C001E00; w[1] = 32'h01000000;
      sendPacket(w, 2, 1'b0, c1);
      @(negedge clk);
      #2 reset_b = 1'b1;
      @(negedge clk);
      reset_b = 1'b0;
      @(posedge clk);
      #1;
      recQ.delete();
      lost0 = lostCount;
      w = '{default: '0};
      w[0] = 32'h0C000C00; w[1] = 32'h09000000; w[2] = 32'h12345678;
      exp6 = mkRec(16'h000C, 8'h04, w, 3);
      sendPacket(w, 3, 1'b1, c1);
      waitRec();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (recQ.size() == 0 || recQ[0] !== exp6) begin
         errors++; $display("FAIL rst_next_record size %0d want record %h", recQ.size(), exp6);
      end
      checks++;
      if (lostCount != lost0) begin errors++; $display("FAIL rst_table_cleared pulses got %0d want 0", lostCount - lost0); end
      $display("test_reset_mid stream 000C S=9 pulses %0d", lostCount - lost0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gap();
      test_seq();
      test_oversize();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
